// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - bfloat16 format constants, FSM states and flag indices for the divider
package bf16_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 7;
    localparam int MANT_W = FRAC_W + 1;
    localparam int QUO_W  = 11;
    localparam int BIAS   = 127;

    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [15:0] POS_INF = 16'h7F80;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_DIV_ZERO  = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

endpackage

// File: rtl/bf16_mant_divider.sv
// rtl/bf16_mant_divider.sv - iterative restoring divider producing a Q1.10 mantissa quotient
module bf16_mant_divider
    import bf16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MANT_W-1:0] ma,
    input  logic [MANT_W-1:0] mb,
    output logic [QUO_W-1:0]  quo,
    output logic              sticky,
    output logic              done
);

    logic [9:0]        rem;
    logic [MANT_W-1:0] div;
    logic [3:0]        cnt;
    logic              busy;
    logic              ge;
    logic [9:0]        rem_sub;

    always_comb begin
        ge      = rem >= {2'b00, div};
        rem_sub = ge ? (rem - {2'b00, div}) : rem;
    end

    // done flags the final iteration; quo and sticky are complete from the next cycle on
    assign done   = busy & (cnt == 4'd10);
    assign sticky = |rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            div  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            quo  <= '0;
        end else if (start) begin
            rem  <= {2'b00, ma};
            div  <= mb;
            cnt  <= '0;
            busy <= 1'b1;
            quo  <= '0;
        end else if (busy) begin
            quo <= {quo[QUO_W-2:0], ge};
            rem <= {rem_sub[8:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd10)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/bf16_divider.sv
// rtl/bf16_divider.sv - multi-cycle bfloat16 divider q = a / b with valid/ready handshake
module bf16_divider
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic [3:0]  flags
);

    state_t           state;
    logic             sign;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;

    logic [EXP_W-1:0]  a_exp, b_exp;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, in_sign;
    logic              special;
    logic [15:0]       spec_q;
    logic [3:0]        spec_flags;
    logic              start;

    logic [QUO_W-1:0]  quo;
    logic              div_sticky;
    logic              div_done;

    logic [QUO_W-1:0]  quo_n;
    logic              shift, guard, st, inc, carry;
    logic [MANT_W:0]   mant_r;
    logic [MANT_W-1:0] mant_f;
    logic signed [9:0] e_calc;
    logic [15:0]       rnd_q;
    logic [3:0]        rnd_flags;

    assign in_ready = (state == IDLE) & rst_n;
    assign start    = (state == IDLE) & in_valid & ~special;

    always_comb begin
        a_exp   = a[14:7];
        b_exp   = b[14:7];
        a_nan   = (a_exp == 8'hFF) & (a[6:0] != 7'd0);
        b_nan   = (b_exp == 8'hFF) & (b[6:0] != 7'd0);
        a_inf   = (a_exp == 8'hFF) & (a[6:0] == 7'd0);
        b_inf   = (b_exp == 8'hFF) & (b[6:0] == 7'd0);
        a_zero  = (a_exp == 8'h00);
        b_zero  = (b_exp == 8'h00);
        in_sign = a[15] ^ b[15];

        special    = 1'b1;
        spec_q     = {in_sign, 15'd0};
        spec_flags = 4'h0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_q                    = QNAN;
            spec_flags[FLAG_INVALID]  = 1'b1;
        end else if (a_inf) begin
            spec_q = {in_sign, POS_INF[14:0]};
        end else if (b_zero) begin
            spec_q                    = {in_sign, POS_INF[14:0]};
            spec_flags[FLAG_DIV_ZERO] = 1'b1;
        end else if (a_zero | b_inf) begin
            spec_q = {in_sign, 15'd0};
        end else begin
            special = 1'b0;
        end
    end

    bf16_mant_divider u_mant_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ma     ({1'b1, a[6:0]}),
        .mb     ({1'b1, b[6:0]}),
        .quo    (quo),
        .sticky (div_sticky),
        .done   (div_done)
    );

    // Normalise into [1,2), round to nearest even, then range-check the biased exponent
    always_comb begin
        shift  = ~quo[QUO_W-1];
        quo_n  = shift ? {quo[QUO_W-2:0], 1'b0} : quo;
        guard  = quo_n[2];
        st     = (|quo_n[1:0]) | div_sticky;
        inc    = guard & (st | quo_n[3]);
        mant_r = {1'b0, quo_n[10:3]} + {{MANT_W{1'b0}}, inc};
        carry  = mant_r[MANT_W];
        mant_f = carry ? 8'h80 : mant_r[MANT_W-1:0];
        e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
               - $signed({9'd0, shift}) + $signed({9'd0, carry});

        rnd_flags = 4'h0;
        if (e_calc >= 10'sd255) begin
            rnd_q                     = {sign, POS_INF[14:0]};
            rnd_flags[FLAG_OVERFLOW]  = 1'b1;
        end else if (e_calc <= 10'sd0) begin
            rnd_q                     = {sign, 15'd0};
            rnd_flags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            rnd_q = {sign, e_calc[7:0], mant_f[FRAC_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            out_valid <= 1'b0;
            q         <= 16'h0000;
            flags     <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= in_sign;
                        ea   <= a_exp;
                        eb   <= b_exp;
                        if (special) begin
                            q         <= spec_q;
                            flags     <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done)
                        state <= ROUND;
                end
                ROUND: begin
                    q         <= rnd_q;
                    flags     <= rnd_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
